// File: rtl/log_drain.sv
// log_drain: drains the violation-log RAM as a framed, checksummed byte stream
module log_drain #(
   parameter logic [15:0] LOG_DEPTH     = 16'h0100,
   parameter bit          CLEAR_ON_DONE = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] log_count,
   output logic        re,
   output logic [15:0] rd_addr,
   input  logic [37:0] rd_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        clr_ram,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, HDR, FETCH, WAIT, SEND, CSUM, CLEAR, DONE} state_t;

   state_t      state_q;
   logic [15:0] cnt_q, idx_q, rd_addr_q;
   logic [2:0]  bcnt_q;
   logic [39:0] sr_q;
   logic [7:0]  csum_q;
   logic        re_q, tx_valid_q, clr_q, done_q;

   logic        xfer;
   logic [15:0] cnt_d, idx_d;
   logic [7:0]  hdr_d;

   // The top byte of the shift register is always the byte on the wire.
   assign xfer     = tx_valid_q & tx_ready;
   assign cnt_d    = (log_count > LOG_DEPTH) ? LOG_DEPTH : log_count;
   assign idx_d    = idx_q + 16'd1;
   assign hdr_d    = (bcnt_q == 3'd0) ? cnt_q[15:8] : cnt_q[7:0];
   assign re       = re_q;
   assign rd_addr  = rd_addr_q;
   assign tx_data  = sr_q[39:32];
   assign tx_valid = tx_valid_q;
   assign clr_ram  = clr_q;
   assign done     = done_q;
   assign busy     = state_q != IDLE;

   // Frame sequencer; every output is registered and the checksum accumulates as each byte is loaded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         rd_addr_q  <= '0;
         bcnt_q     <= '0;
         sr_q       <= '0;
         csum_q     <= '0;
         re_q       <= 1'b0;
         tx_valid_q <= 1'b0;
         clr_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               cnt_q      <= cnt_d;
               idx_q      <= '0;
               csum_q     <= '0;
               bcnt_q     <= '0;
               sr_q       <= {8'hA5, 32'h0};
               tx_valid_q <= 1'b1;
               state_q    <= HDR;
            end
            HDR: if (xfer) begin
               if (bcnt_q == 3'd2) begin
                  bcnt_q <= '0;
                  if (cnt_q == 16'd0) begin
                     sr_q[39:32] <= csum_q;
                     state_q     <= CSUM;
                  end else begin
                     tx_valid_q <= 1'b0;
                     re_q       <= 1'b1;
                     rd_addr_q  <= idx_q;
                     state_q    <= FETCH;
                  end
               end else begin
                  bcnt_q      <= bcnt_q + 3'd1;
                  sr_q[39:32] <= hdr_d;
                  csum_q      <= csum_q ^ hdr_d;
               end
            end
            FETCH: begin
               re_q    <= 1'b0;
               state_q <= WAIT;
            end
            WAIT: begin
               sr_q       <= {2'b00, rd_data};
               csum_q     <= csum_q ^ {2'b00, rd_data[37:32]};
               tx_valid_q <= 1'b1;
               state_q    <= SEND;
            end
            SEND: if (xfer) begin
               if (bcnt_q == 3'd4) begin
                  bcnt_q <= '0;
                  idx_q  <= idx_d;
                  if (idx_d == cnt_q) begin
                     sr_q[39:32] <= csum_q;
                     state_q     <= CSUM;
                  end else begin
                     tx_valid_q <= 1'b0;
                     re_q       <= 1'b1;
                     rd_addr_q  <= idx_d;
                     state_q    <= FETCH;
                  end
               end else begin
                  bcnt_q <= bcnt_q + 3'd1;
                  sr_q   <= sr_q << 8;
                  csum_q <= csum_q ^ sr_q[31:24];
               end
            end
            CSUM: if (xfer) begin
               tx_valid_q <= 1'b0;
               if (CLEAR_ON_DONE) begin
                  clr_q   <= 1'b1;
                  state_q <= CLEAR;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            CLEAR: begin
               clr_q   <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_log_drain.sv
// tb_log_drain: scoreboard bench for the log drain frame stream
module tb_log_drain;

   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, tx_ready = 1'b1, bp = 1'b0;
   logic [15:0] log_count = '0;
   logic [37:0] rd_data = '0;
   logic        re, tx_valid, clr_ram, busy, done;
   logic [15:0] rd_addr;
   logic [7:0]  tx_data;

   int nvec = 0, nerr = 0, cyc = 0, reads = 0, clrs = 0, dones = 0;
   int clr_cyc = 0, done_cyc = 0, rd_base = 0;
   logic [7:0]  exp_q[$];
   logic [37:0] ram [0:255];
   logic        stall = 1'b0;
   logic [7:0]  stall_data = '0;

   logic [7:0] fa [14] = '{8'hA5, 8'h00, 8'h02, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                           8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
   logic [7:0] fb [4]  = '{8'hA5, 8'h00, 8'h00, 8'h00};

   log_drain dut (
      .clk(clk), .reset_n(reset_n), .start(start), .log_count(log_count),
      .re(re), .rd_addr(rd_addr), .rd_data(rd_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .clr_ram(clr_ram), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // RAM model: data appears the cycle after re
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (re) rd_data <= ram[rd_addr[7:0]];
   end

   initial forever begin
      @(posedge clk);
      #1;
      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: pops the scoreboard on every transfer and watches the side signals
   always @(negedge clk) begin
      if (!reset_n) stall = 1'b0;
      else begin
         if (stall) check("stall_hold", {tx_valid, tx_data}, {1'b1, stall_data});
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL extra_byte: got %0h expected none", tx_data);
            end else check("byte", tx_data, exp_q.pop_front());
         end
         stall = tx_valid && !tx_ready;
         stall_data = tx_data;
         if (re) begin
            check("rd_addr", rd_addr, 16'(reads - rd_base));
            check("valid_in_fetch", tx_valid, 0);
            reads++;
         end
         if (clr_ram) begin clrs++; clr_cyc = cyc; end
         if (done) begin dones++; done_cyc = cyc; end
      end
   end

   task automatic push_a();
      foreach (fa[i]) exp_q.push_back(fa[i]);
   endtask

   task automatic push_model(input logic [15:0] c);
      logic [15:0] cl;
      logic [7:0]  x, b;
      logic [37:0] e;
      cl = (c > 16'h0100) ? 16'h0100 : c;
      x = cl[15:8] ^ cl[7:0];
      exp_q.push_back(8'hA5);
      exp_q.push_back(cl[15:8]);
      exp_q.push_back(cl[7:0]);
      for (int i = 0; i < int'(cl); i++) begin
         e = ram[i];
         for (int k = 4; k >= 0; k--) begin
            b = (k == 4) ? {2'b00, e[37:32]} : 8'(e >> (8 * k));
            x ^= b;
            exp_q.push_back(b);
         end
      end
      exp_q.push_back(x);
   endtask

   task automatic run_frame(input logic [15:0] lc, input int exp_cyc, input int exp_rd);
      int n, b_rd, b_clr, b_dn;
      b_rd = reads; b_clr = clrs; b_dn = dones; rd_base = reads;
      @(negedge clk);
      start = 1'b1;
      log_count = lc;
      @(posedge clk);
      n = 1;
      #1 start = 1'b0;
      check("busy_rise", busy, 1);
      check("first_valid", {tx_valid, tx_data}, {1'b1, 8'hA5});
      while (!done && n < 5000) begin
         @(posedge clk);
         n++;
         #1;
      end
      check("done_seen", done, 1);
      if (exp_cyc > 0) check("cycles", n, exp_cyc);
      @(negedge clk);
      #1;
      check("done_pulses", dones - b_dn, 1);
      check("clr_pulses", clrs - b_clr, 1);
      check("clr_then_done", done_cyc - clr_cyc, 1);
      check("reads", reads - b_rd, exp_rd);
      check("bytes_left", exp_q.size(), 0);
      @(posedge clk);
      #1;
      check("idle_after", {busy, done, tx_valid}, 0);
   endtask

   initial begin
      int n, b_clr, b_dn;
      ram[0] = 38'h2_1234_5678;
      ram[1] = 38'h0_DEAD_BEEF;
      repeat (3) @(negedge clk);
      check("reset_out", {re, rd_addr, tx_valid, tx_data, clr_ram, busy, done}, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_out", {re, rd_addr, tx_valid, tx_data, clr_ram, busy, done}, 0);

      push_a();
      run_frame(16'd2, 20, 2);

      foreach (fb[i]) exp_q.push_back(fb[i]);
      run_frame(16'd0, 6, 0);

      bp = 1'b1;
      push_a();
      run_frame(16'd2, 0, 2);
      bp = 1'b0;

      push_a();
      fork
         run_frame(16'd2, 20, 2);
         begin
            repeat (8) @(negedge clk);
            start = 1'b1;
            log_count = 16'd5;
            @(negedge clk);
            start = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      check("no_restart", busy, 0);

      b_clr = clrs; b_dn = dones; rd_base = reads;
      push_a();
      @(negedge clk);
      start = 1'b1;
      log_count = 16'd2;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (!(re && rd_addr == 16'd1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reached_entry1", {re, rd_addr}, {1'b1, 16'd1});
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check("async_reset", {re, rd_addr, tx_valid, tx_data, clr_ram, busy, done}, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("abort_no_clr", clrs - b_clr, 0);
      check("abort_no_done", dones - b_dn, 0);
      reset_n = 1'b1;
      push_a();
      run_frame(16'd2, 20, 2);

      for (int i = 0; i < 256; i++) ram[i] = {6'(i * 7), 32'(i) * 32'h0101_0101 ^ 32'hA5A5_5A5A};
      push_model(16'h0300);
      run_frame(16'h0300, 1798, 256);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
